// File: rtl/memory_stage.sv
// MEM pipeline stage: holds the EXE->MEM bundle, issues one data SRAM
// request per load/store and hands the result to WB.
module memory_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        exe_valid,
  output logic        mem_allowin,
  input  logic [2:0]  load_op_EXE_MEM,
  input  logic [2:0]  store_op_EXE_MEM,
  input  logic [31:0] ALUResult_EXE_MEM,
  input  logic [31:0] RegRdata2_EXE_MEM,
  input  logic [31:0] PC_EXE_MEM,
  input  logic [31:0] HI_EXE_MEM,
  input  logic [31:0] LO_EXE_MEM,
  input  logic [31:0] cp0Rdata_EXE_MEM,
  input  logic [3:0]  RegWrite_EXE_MEM,
  input  logic [4:0]  RegWaddr_EXE_MEM,
  input  logic [1:0]  MFHL_EXE_MEM,
  input  logic        MemToReg_EXE_MEM,
  input  logic        mfc0_EXE_MEM,
  output logic        data_req,
  output logic        data_wr,
  output logic [3:0]  data_wen,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  input  logic        wb_allowin,
  output logic        mem_wb_valid,
  output logic [31:0] ALUResult_MEM_WB,
  output logic [31:0] RegRdata2_MEM_WB,
  output logic [31:0] PC_MEM_WB,
  output logic [31:0] HI_MEM_WB,
  output logic [31:0] LO_MEM_WB,
  output logic [31:0] cp0Rdata_MEM_WB,
  output logic [3:0]  RegWrite_MEM_WB,
  output logic [4:0]  RegWaddr_MEM_WB,
  output logic [1:0]  MFHL_MEM_WB,
  output logic        MemToReg_MEM_WB,
  output logic        mfc0_MEM_WB,
  output logic        LB_MEM_WB,
  output logic        LBU_MEM_WB,
  output logic        LH_MEM_WB,
  output logic        LHU_MEM_WB,
  output logic [1:0]  LW_MEM_WB,
  output logic [31:0] MemRdata_MEM_WB
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      state;
  logic        mem_valid;
  logic [2:0]  load_op;
  logic [2:0]  store_op;
  logic        is_load, is_store, is_mem;
  logic        exe_is_mem;
  logic        load_en;
  logic        next_mem;
  logic        mem_ready;
  logic [1:0]  a;

  assign is_load    = (load_op != 3'd0);
  assign is_store   = (store_op >= 3'd1) && (store_op <= 3'd5);
  assign is_mem     = is_load || is_store;
  assign exe_is_mem = (load_op_EXE_MEM != 3'd0) ||
                      ((store_op_EXE_MEM >= 3'd1) && (store_op_EXE_MEM <= 3'd5));

  assign mem_ready    = (mem_valid && !is_mem) || (state == S_DONE) ||
                        ((state == S_WAIT) && data_data_ok);
  assign mem_allowin  = !mem_valid || (mem_ready && wb_allowin);
  assign mem_wb_valid = mem_valid && mem_ready;
  assign load_en      = exe_valid && mem_allowin;
  assign next_mem     = load_en && exe_is_mem;

  // Pipeline register: bundle loads on accept, valid follows exe_valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_valid        <= 1'b0;
      load_op          <= '0;
      store_op         <= '0;
      ALUResult_MEM_WB <= '0;
      RegRdata2_MEM_WB <= '0;
      PC_MEM_WB        <= '0;
      HI_MEM_WB        <= '0;
      LO_MEM_WB        <= '0;
      cp0Rdata_MEM_WB  <= '0;
      RegWrite_MEM_WB  <= '0;
      RegWaddr_MEM_WB  <= '0;
      MFHL_MEM_WB      <= '0;
      MemToReg_MEM_WB  <= 1'b0;
      mfc0_MEM_WB      <= 1'b0;
      LB_MEM_WB        <= 1'b0;
      LBU_MEM_WB       <= 1'b0;
      LH_MEM_WB        <= 1'b0;
      LHU_MEM_WB       <= 1'b0;
      LW_MEM_WB        <= '0;
    end else begin
      if (mem_allowin) mem_valid <= exe_valid;
      if (load_en) begin
        load_op          <= load_op_EXE_MEM;
        store_op         <= store_op_EXE_MEM;
        ALUResult_MEM_WB <= ALUResult_EXE_MEM;
        RegRdata2_MEM_WB <= RegRdata2_EXE_MEM;
        PC_MEM_WB        <= PC_EXE_MEM;
        HI_MEM_WB        <= HI_EXE_MEM;
        LO_MEM_WB        <= LO_EXE_MEM;
        cp0Rdata_MEM_WB  <= cp0Rdata_EXE_MEM;
        RegWrite_MEM_WB  <= RegWrite_EXE_MEM;
        RegWaddr_MEM_WB  <= RegWaddr_EXE_MEM;
        MFHL_MEM_WB      <= MFHL_EXE_MEM;
        MemToReg_MEM_WB  <= MemToReg_EXE_MEM;
        mfc0_MEM_WB      <= mfc0_EXE_MEM;
        LB_MEM_WB        <= (load_op_EXE_MEM == 3'd1);
        LBU_MEM_WB       <= (load_op_EXE_MEM == 3'd2);
        LH_MEM_WB        <= (load_op_EXE_MEM == 3'd3);
        LHU_MEM_WB       <= (load_op_EXE_MEM == 3'd4);
        case (load_op_EXE_MEM)
          3'd5:    LW_MEM_WB <= 2'b11;
          3'd6:    LW_MEM_WB <= 2'b10;
          3'd7:    LW_MEM_WB <= 2'b01;
          default: LW_MEM_WB <= 2'b00;
        endcase
      end
    end
  end

  // Request FSM; data_req is a registered output set on entry to S_REQ
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      data_req <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (next_mem) begin
          state    <= S_REQ;
          data_req <= 1'b1;
        end
        S_REQ: if (data_addr_ok) begin
          state    <= S_WAIT;
          data_req <= 1'b0;
        end
        S_WAIT: if (data_data_ok) begin
          if (!wb_allowin)   state <= S_DONE;
          else if (next_mem) begin
            state    <= S_REQ;
            data_req <= 1'b1;
          end else           state <= S_IDLE;
        end
        S_DONE: if (wb_allowin) begin
          if (next_mem) begin
            state    <= S_REQ;
            data_req <= 1'b1;
          end else   state <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          data_req <= 1'b0;
        end
      endcase
    end
  end

  // Read data capture, only on completion while waiting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  MemRdata_MEM_WB <= '0;
    else if ((state == S_WAIT) && data_data_ok) MemRdata_MEM_WB <= data_rdata;
  end

  assign a         = ALUResult_MEM_WB[1:0];
  assign data_addr = {ALUResult_MEM_WB[31:2], 2'b00};
  assign data_wr   = is_store;

  // Byte-lane enables and aligned write data for the held store
  always_comb begin
    data_wen   = '0;
    data_wdata = RegRdata2_MEM_WB;
    case (store_op)
      3'd1: begin
        data_wen   = 4'b0001 << a;
        data_wdata = {4{RegRdata2_MEM_WB[7:0]}};
      end
      3'd2: begin
        data_wen   = (a == 2'd0) ? 4'b0011 : (a == 2'd2) ? 4'b1100 : 4'b0000;
        data_wdata = {2{RegRdata2_MEM_WB[15:0]}};
      end
      3'd3: data_wen = 4'b1111;
      3'd4: begin
        case (a)
          2'd0: begin data_wen = 4'b0001; data_wdata = {24'd0, RegRdata2_MEM_WB[31:24]}; end
          2'd1: begin data_wen = 4'b0011; data_wdata = {16'd0, RegRdata2_MEM_WB[31:16]}; end
          2'd2: begin data_wen = 4'b0111; data_wdata = {8'd0,  RegRdata2_MEM_WB[31:8]};  end
          default: begin data_wen = 4'b1111; data_wdata = RegRdata2_MEM_WB; end
        endcase
      end
      3'd5: begin
        case (a)
          2'd0: begin data_wen = 4'b1111; data_wdata = RegRdata2_MEM_WB; end
          2'd1: begin data_wen = 4'b1110; data_wdata = {RegRdata2_MEM_WB[23:0], 8'd0};  end
          2'd2: begin data_wen = 4'b1100; data_wdata = {RegRdata2_MEM_WB[15:0], 16'd0}; end
          default: begin data_wen = 4'b1000; data_wdata = {RegRdata2_MEM_WB[7:0], 24'd0}; end
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: reset, load handshake, store lanes,
// WB back-pressure, back-to-back issue and reset mid-transaction.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        exe_valid;
  logic        mem_allowin;
  logic [2:0]  load_op, store_op;
  logic [31:0] alu, rt, pc, hi, lo, cp0;
  logic [3:0]  regwrite;
  logic [4:0]  waddr;
  logic [1:0]  mfhl;
  logic        memtoreg, mfc0;
  logic        data_req, data_wr;
  logic [3:0]  data_wen;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        wb_allowin;
  logic        mem_wb_valid;
  logic [31:0] alu_wb, rt_wb, pc_wb, hi_wb, lo_wb, cp0_wb;
  logic [3:0]  regwrite_wb;
  logic [4:0]  waddr_wb;
  logic [1:0]  mfhl_wb;
  logic        memtoreg_wb, mfc0_wb;
  logic        lb_wb, lbu_wb, lh_wb, lhu_wb;
  logic [1:0]  lw_wb;
  logic [31:0] rdata_wb;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  memory_stage dut (
    .clk(clk), .rst(rst), .exe_valid(exe_valid), .mem_allowin(mem_allowin),
    .load_op_EXE_MEM(load_op), .store_op_EXE_MEM(store_op),
    .ALUResult_EXE_MEM(alu), .RegRdata2_EXE_MEM(rt), .PC_EXE_MEM(pc),
    .HI_EXE_MEM(hi), .LO_EXE_MEM(lo), .cp0Rdata_EXE_MEM(cp0),
    .RegWrite_EXE_MEM(regwrite), .RegWaddr_EXE_MEM(waddr), .MFHL_EXE_MEM(mfhl),
    .MemToReg_EXE_MEM(memtoreg), .mfc0_EXE_MEM(mfc0),
    .data_req(data_req), .data_wr(data_wr), .data_wen(data_wen),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .wb_allowin(wb_allowin), .mem_wb_valid(mem_wb_valid),
    .ALUResult_MEM_WB(alu_wb), .RegRdata2_MEM_WB(rt_wb), .PC_MEM_WB(pc_wb),
    .HI_MEM_WB(hi_wb), .LO_MEM_WB(lo_wb), .cp0Rdata_MEM_WB(cp0_wb),
    .RegWrite_MEM_WB(regwrite_wb), .RegWaddr_MEM_WB(waddr_wb), .MFHL_MEM_WB(mfhl_wb),
    .MemToReg_MEM_WB(memtoreg_wb), .mfc0_MEM_WB(mfc0_wb),
    .LB_MEM_WB(lb_wb), .LBU_MEM_WB(lbu_wb), .LH_MEM_WB(lh_wb), .LHU_MEM_WB(lhu_wb),
    .LW_MEM_WB(lw_wb), .MemRdata_MEM_WB(rdata_wb)
  );

  // Advance to 1 time unit after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] lop, input logic [2:0] sop,
                       input logic [31:0] addr, input logic [31:0] data);
    exe_valid = 1'b1;
    load_op   = lop;
    store_op  = sop;
    alu       = addr;
    rt        = data;
  endtask

  // Drive addr_ok then data_ok for one cycle each from state REQ
  task automatic finish_txn();
    exe_valid    = 1'b0;
    data_addr_ok = 1'b1;
    cyc();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    cyc();
    data_data_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    issue(3'd5, 3'd0, 32'h0000_1004, 32'h0);
    cyc();
    cyc();
    tests++; if (data_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b exp 0", data_req); end
    tests++; if (mem_wb_valid !== 1'b0) begin fails++; $display("FAIL reset_wbv: got %b exp 0", mem_wb_valid); end
    tests++; if (mem_allowin !== 1'b1) begin fails++; $display("FAIL reset_allowin: got %b exp 1", mem_allowin); end
    tests++; if (alu_wb !== 32'h0 || lw_wb !== 2'b00 || rdata_wb !== 32'h0)
      begin fails++; $display("FAIL reset_regs: got alu=%h lw=%b rdata=%h exp 0", alu_wb, lw_wb, rdata_wb); end
    exe_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cyc();
    tests++; if (data_req !== 1'b0) begin fails++; $display("FAIL reset_release_req: got %b exp 0", data_req); end
  endtask

  task automatic test_lw();
    int req_cycles = 0;
    int wbv_cycles = 0;
    issue(3'd5, 3'd0, 32'h0000_1004, 32'h0);
    wb_allowin = 1'b1;
    cyc();
    exe_valid = 1'b0;
    tests++; if (data_addr !== 32'h0000_1004) begin fails++; $display("FAIL lw_addr: got %h exp 00001004", data_addr); end
    tests++; if (lw_wb !== 2'b11) begin fails++; $display("FAIL lw_decode: got %b exp 11", lw_wb); end
    tests++; if (data_wr !== 1'b0 || data_wen !== 4'b0000)
      begin fails++; $display("FAIL lw_wr: got wr=%b wen=%b exp 0 0000", data_wr, data_wen); end
    for (int i = 0; i < 6; i++) begin
      data_addr_ok = (i == 2);
      data_data_ok = (i == 3);
      data_rdata   = (i == 3) ? 32'hDEAD_BEEF : 32'h0BAD_0BAD;
      #1;
      if (data_req)     req_cycles++;
      if (mem_wb_valid) wbv_cycles++;
      cyc();
    end
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    tests++; if (req_cycles != 3) begin fails++; $display("FAIL lw_req_cycles: got %0d exp 3", req_cycles); end
    tests++; if (wbv_cycles != 1) begin fails++; $display("FAIL lw_wbv_cycles: got %0d exp 1", wbv_cycles); end
    tests++; if (rdata_wb !== 32'hDEAD_BEEF) begin fails++; $display("FAIL lw_rdata: got %h exp deadbeef", rdata_wb); end
  endtask

  task automatic test_store_lanes();
    logic [2:0]  sop [6];
    logic [31:0] addr [6];
    logic [31:0] data [6];
    logic [3:0]  exp_wen [6];
    logic [31:0] exp_wdata [6];
    logic [31:0] exp_addr [6];
    sop[0]=3'd1; addr[0]=32'h2003; data[0]=32'h0000_00A5; exp_wen[0]=4'b1000; exp_wdata[0]=32'hA5A5_A5A5; exp_addr[0]=32'h2000;
    sop[1]=3'd4; addr[1]=32'h3001; data[1]=32'h1122_3344; exp_wen[1]=4'b0011; exp_wdata[1]=32'h0000_1122; exp_addr[1]=32'h3000;
    sop[2]=3'd5; addr[2]=32'h3002; data[2]=32'h1122_3344; exp_wen[2]=4'b1100; exp_wdata[2]=32'h3344_0000; exp_addr[2]=32'h3000;
    sop[3]=3'd2; addr[3]=32'h4002; data[3]=32'h1122_3344; exp_wen[3]=4'b1100; exp_wdata[3]=32'h3344_3344; exp_addr[3]=32'h4000;
    sop[4]=3'd2; addr[4]=32'h4001; data[4]=32'h1122_3344; exp_wen[4]=4'b0000; exp_wdata[4]=32'h3344_3344; exp_addr[4]=32'h4000;
    sop[5]=3'd3; addr[5]=32'h5008; data[5]=32'hCAFE_0001; exp_wen[5]=4'b1111; exp_wdata[5]=32'hCAFE_0001; exp_addr[5]=32'h5008;
    wb_allowin = 1'b1;
    for (int i = 0; i < 6; i++) begin
      issue(3'd0, sop[i], addr[i], data[i]);
      cyc();
      tests++;
      if (data_req !== 1'b1 || data_wr !== 1'b1 || data_wen !== exp_wen[i] ||
          data_wdata !== exp_wdata[i] || data_addr !== exp_addr[i]) begin
        fails++;
        $display("FAIL store_%0d: got req=%b wr=%b wen=%b wdata=%h addr=%h exp 1 1 %b %h %h",
                 i, data_req, data_wr, data_wen, data_wdata, data_addr,
                 exp_wen[i], exp_wdata[i], exp_addr[i]);
      end
      finish_txn();
    end
  endtask

  task automatic test_done_hold();
    issue(3'd5, 3'd0, 32'h0000_3000, 32'h0);
    wb_allowin = 1'b1;
    cyc();
    finish_txn_addr_only();
    data_data_ok = 1'b1;
    data_rdata   = 32'hCAFE_F00D;
    wb_allowin   = 1'b0;
    #1;
    tests++; if (mem_wb_valid !== 1'b1 || mem_allowin !== 1'b0)
      begin fails++; $display("FAIL hold_ok_cycle: got wbv=%b allowin=%b exp 1 0", mem_wb_valid, mem_allowin); end
    cyc();
    data_data_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_data_ok = (i == 1);
      data_rdata   = 32'h1234_5678;
      #1;
      tests++;
      if (mem_wb_valid !== 1'b1 || mem_allowin !== 1'b0 || data_req !== 1'b0 || rdata_wb !== 32'hCAFE_F00D) begin
        fails++;
        $display("FAIL hold_done_%0d: got wbv=%b allowin=%b req=%b rdata=%h exp 1 0 0 cafef00d",
                 i, mem_wb_valid, mem_allowin, data_req, rdata_wb);
      end
      cyc();
    end
    data_data_ok = 1'b0;
    wb_allowin   = 1'b1;
    #1;
    tests++; if (mem_wb_valid !== 1'b1 || mem_allowin !== 1'b1)
      begin fails++; $display("FAIL hold_release: got wbv=%b allowin=%b exp 1 1", mem_wb_valid, mem_allowin); end
    cyc();
    tests++; if (mem_wb_valid !== 1'b0 || data_req !== 1'b0)
      begin fails++; $display("FAIL hold_after: got wbv=%b req=%b exp 0 0", mem_wb_valid, data_req); end
  endtask

  task automatic finish_txn_addr_only();
    exe_valid    = 1'b0;
    data_addr_ok = 1'b1;
    cyc();
    data_addr_ok = 1'b0;
  endtask

  task automatic test_back_to_back();
    wb_allowin = 1'b1;
    issue(3'd0, 3'd0, 32'h0000_0042, 32'h0);
    waddr = 5'd5;
    cyc();
    issue(3'd5, 3'd0, 32'h0000_4008, 32'h0);
    waddr = 5'd9;
    #1;
    tests++; if (mem_wb_valid !== 1'b1 || mem_allowin !== 1'b1 || waddr_wb !== 5'd5 || data_req !== 1'b0)
      begin fails++; $display("FAIL b2b_alu: got wbv=%b allowin=%b waddr=%0d req=%b exp 1 1 5 0",
                              mem_wb_valid, mem_allowin, waddr_wb, data_req); end
    cyc();
    exe_valid = 1'b0;
    tests++; if (data_req !== 1'b1 || data_addr !== 32'h0000_4008 || mem_wb_valid !== 1'b0 || waddr_wb !== 5'd9)
      begin fails++; $display("FAIL b2b_lw: got req=%b addr=%h wbv=%b waddr=%0d exp 1 00004008 0 9",
                              data_req, data_addr, mem_wb_valid, waddr_wb); end
    finish_txn();
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    wb_allowin = 1'b1;
    issue(3'd5, 3'd0, 32'h0000_6000, 32'h0);
    cyc();
    finish_txn_addr_only();
    #2;
    rst = 1'b0;
    #1;
    tests++; if (data_req !== 1'b0 || mem_wb_valid !== 1'b0 || lw_wb !== 2'b00)
      begin fails++; $display("FAIL rstmid_now: got req=%b wbv=%b lw=%b exp 0 0 00", data_req, mem_wb_valid, lw_wb); end
    cyc();
    @(negedge clk);
    rst = 1'b1;
    cyc();
    data_data_ok = 1'b1;
    data_rdata   = 32'hFEED_FACE;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (mem_wb_valid !== 1'b0 || data_req !== 1'b0) bad++;
      cyc();
      data_data_ok = 1'b0;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL rstmid_late_ok: got %0d bad cycles exp 0", bad); end
    tests++; if (rdata_wb !== 32'h0) begin fails++; $display("FAIL rstmid_rdata: got %h exp 0", rdata_wb); end
  endtask

  initial begin
    rst = 1'b0; exe_valid = 1'b0; load_op = '0; store_op = '0;
    alu = '0; rt = '0; pc = 32'hBFC0_0000; hi = '0; lo = '0; cp0 = '0;
    regwrite = 4'hF; waddr = '0; mfhl = '0; memtoreg = 1'b0; mfc0 = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0; wb_allowin = 1'b1;
    #1;
    test_reset();
    test_lw();
    test_store_lanes();
    test_done_hold();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameters: none; all widths are fixed as listed below.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-low.
REQ-004 exe_valid  in  1  EXE stage presents a valid instruction.
REQ-005 mem_allowin  out  1  MEM can accept from EXE this cycle.
REQ-006 load_op_EXE_MEM  in  3  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWL, 7 LWR.
REQ-007 store_op_EXE_MEM  in  3  0 none, 1 SB, 2 SH, 3 SW, 4 SWL, 5 SWR; 6–7 are treated as none.
REQ-008 ALUResult_EXE_MEM, RegRdata2_EXE_MEM, PC_EXE_MEM, HI_EXE_MEM, LO_EXE_MEM, cp0Rdata_EXE_MEM  in  32 each  datapath bundle.
REQ-009 RegWrite_EXE_MEM (4), RegWaddr_EXE_MEM (5), MFHL_EXE_MEM (2), MemToReg_EXE_MEM (1), mfc0_EXE_MEM (1)  in  control bundle.
REQ-010 data_req, data_wr  out  1 each; data_wen  out  4; data_addr, data_wdata  out  32 each: data SRAM request.
REQ-011 data_addr_ok, data_data_ok  in  1 each; data_rdata  in  32: SRAM acceptance, completion and read data.
REQ-012 wb_allowin  in  1  WB can accept this cycle.
REQ-013 mem_wb_valid  out  1  MEM-to-WB output bundle is valid.
REQ-014 Outputs to WB, each a registered copy of the matching input:
  - *_MEM_WB for every REQ-008 and REQ-009 field.
  - LB/LBU/LH/LHU_MEM_WB (1 each) and LW_MEM_WB (2) decoded from load_op: LW=11, LWL=10, LWR=01, otherwise 00.
  - MemRdata_MEM_WB  out  32  captured data_rdata.

Function
REQ-015 Pipeline register: the MEM bundle loads from EXE when exe_valid && mem_allowin; mem_valid is set to exe_valid on that same edge.
REQ-016 mem_allowin = !mem_valid || (mem_ready && wb_allowin).
REQ-017 mem_ready is high in any of these cases:
  - mem_valid with no memory op;
  - state DONE;
  - state WAIT with data_data_ok high.
REQ-018 mem_wb_valid = mem_valid && mem_ready.
REQ-019 FSM states are IDLE, REQ, WAIT and DONE.
REQ-020 IDLE -> REQ on the edge that loads a memory-op instruction; otherwise stay in IDLE.
REQ-021 REQ: data_req=1; the request moves to WAIT on data_addr_ok.
REQ-022 WAIT: data_req=0. On data_data_ok:
  - with wb_allowin: go to REQ if a new memory-op instruction loads on that edge, else IDLE;
  - without wb_allowin: go to DONE.
REQ-023 DONE: hold until wb_allowin, then take the same next-state decision as REQ-022.
REQ-024 data_rdata is captured into MemRdata_MEM_WB on every data_data_ok cycle in WAIT; it holds until the next capture.
REQ-025 data_addr, data_wr, data_wen and data_wdata are functions of the registered bundle only; they are stable throughout REQ.
REQ-026 data_addr = {ALUResult[31:2], 2'b00}.
REQ-027 Let a = ALUResult[1:0] and rt = RegRdata2.
REQ-028 Loads: data_wr=0, data_wen=0000.
REQ-029 SB: wen = 0001 << a, wdata = {4{rt[7:0]}}.
REQ-030 SH: wen = 0011 (a=0) or 1100 (a=2), wdata = {2{rt[15:0]}}; for a = 1 or 3, wen=0000.
REQ-031 SW: wen = 1111, wdata = rt.
REQ-032 SWL: wen = 0001/0011/0111/1111 for a = 0/1/2/3; wdata = rt >> (24 - 8a).
REQ-033 SWR: wen = 1111/1110/1100/1000 for a = 0/1/2/3; wdata = rt << 8a.
REQ-034 Stores also wait for data_data_ok before becoming ready; data_rdata is captured but ignored downstream.
REQ-035 data_data_ok outside WAIT, or data_addr_ok outside REQ, is ignored.
REQ-036 When mem_valid=0, or the op is not a memory op, data_req=0.

Reset
REQ-037 On rst low, immediately and independent of clk:
  - mem_valid=0, state=IDLE, data_req=0;
  - every *_MEM_WB register, MemRdata_MEM_WB and mem_wb_valid = 0.
REQ-038 Reset asserted mid-transaction abandons the request; no request is reissued after release.
REQ-039 The first request after reset occurs no earlier than the cycle after the first load edge.

Verification
REQ-040 LW at 0x1004, addr_ok after 2 cycles, data_ok 1 cycle later with rdata 0xDEADBEEF, wb_allowin=1:
  - data_addr=0x1004, data_req high for 3 cycles;
  - mem_wb_valid for exactly 1 cycle; MemRdata_MEM_WB=0xDEADBEEF; LW_MEM_WB=11.
REQ-041 SB rt=0x000000A5 with ALUResult=0x2003:
  - wen=1000, wdata=0xA5A5A5A5, data_wr=1, addr=0x2000.
REQ-042 SWL rt=0x11223344 with a=1:
  - wen=0011, wdata=0x00001122.
REQ-043 SWR with the same rt and a=2:
  - wen=1100, wdata=0x33440000.
REQ-044 data_ok arrives while wb_allowin=0 for 3 cycles:
  - state DONE for those cycles; mem_allowin=0;
  - rdata is held; mem_wb_valid stays high until the handoff.
REQ-045 Back-to-back ALU op then LW with wb_allowin=1:
  - ALU op passes in 1 cycle; LW enters REQ on the next edge without a bubble.
REQ-046 rst pulled low during WAIT:
  - data_req=0 and mem_wb_valid=0 immediately;
  - a late data_ok after release is ignored, with no spurious mem_wb_valid.
